uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rr_pick.sv | 43 ++++
 rtl/uart_tx_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and default constants for the UART transmit arbiter.
// Contents: arb_state_t (arbiter FSM encoding), UART_NUM_REQ_DEF, UART_TIMEOUT_DEF.
// Used by uart_tx_arbiter and uart_rr_pick.
package uart_pkg;

   localparam int UART_NUM_REQ_DEF = 4;
   localparam int UART_TIMEOUT_DEF = 1024;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOCK      = 3'd1,
      ST_ISSUE     = 3'd2,
      ST_WAIT_ACK  = 3'd3,
      ST_WAIT_DONE = 3'd4
   } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational rotating-priority picker, first valid at or after i_ptr.
// Ports: i_valid (request vector), i_ptr (priority start index),
//        o_gnt (one-hot winner), o_idx (winner index), o_any (some request valid).
module uart_rr_pick
   import uart_pkg::*;
#(
   parameter int NUM_REQ = UART_NUM_REQ_DEF,
   parameter int PW      = $clog2(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] i_valid,
   input  logic [PW-1:0]      i_ptr,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [PW-1:0]      o_idx,
   output logic               o_any
);

   logic [PW-1:0] w_pos;

   // i_ptr + off, wrapped at NUM_REQ (i_ptr is always < NUM_REQ)
   function automatic logic [PW-1:0] wrap_add(logic [PW-1:0] base, int unsigned off);
      int unsigned s;
      s = 32'(base) + off;
      if (s >= 32'(NUM_REQ)) s = s - 32'(NUM_REQ);
      return s[PW-1:0];
   endfunction

   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      w_pos = '0;
      // walk positions in priority order; the first valid one wins
      for (int k = 0; k < NUM_REQ; k++) begin
         w_pos = wrap_add(i_ptr, unsigned'(k));
         if (!o_any && i_valid[w_pos]) begin
            o_any        = 1'b1;
            o_gnt[w_pos] = 1'b1;
            o_idx        = w_pos;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-locked round-robin arbiter feeding one UART transmitter.
// Ports: clk, rst (async active-low); req_valid/req_data/req_last/req_ready per requester;
//        grant (one-hot owner); tx_data/tx_valid/tx_ready to the UART; busy; timeout.
// Optional owner-stall release is compiled in with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ        = UART_NUM_REQ_DEF,
   parameter int TIMEOUT_CYCLES = UART_TIMEOUT_DEF
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [NUM_REQ-1:0]   grant,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic                 busy,
   output logic                 timeout
);

   localparam int PW = $clog2(NUM_REQ);

   arb_state_t         r_state;
   arb_state_t         w_state_nxt;
   logic [PW-1:0]      r_ptr;
   logic [PW-1:0]      r_owner;
   logic [NUM_REQ-1:0] r_grant;
   logic [7:0]         r_tx_data;
   logic               r_last;

   logic [NUM_REQ-1:0] w_pick_gnt;
   logic [PW-1:0]      w_pick_idx;
   logic               w_pick_any;
   logic               w_own_vld;
   logic               w_accept;
   logic               w_release;
   logic               w_stall_to;
   logic [PW-1:0]      w_ptr_after_owner;

   uart_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PW      (PW)
   ) u_pick (
      .i_valid (req_valid),
      .i_ptr   (r_ptr),
      .o_gnt   (w_pick_gnt),
      .o_idx   (w_pick_idx),
      .o_any   (w_pick_any)
   );

   assign w_own_vld         = req_valid[r_owner];
   assign w_ptr_after_owner = (r_owner == PW'(NUM_REQ-1)) ? '0 : r_owner + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
   // Counts consecutive LOCK cycles in which the owner offers nothing;
   // the release fires on the TIMEOUT_CYCLES-th such cycle.
   logic [15:0] r_stall_cnt;

   assign w_stall_to = (r_state == ST_LOCK) && !w_own_vld &&
                       (r_stall_cnt == 16'(TIMEOUT_CYCLES-1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= '0;
      end else if ((r_state == ST_LOCK) && !w_own_vld && !w_stall_to) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end else begin
         r_stall_cnt <= '0;
      end
   end
`else
   // Lock is held for as long as the owner takes; the stall limit is unused.
   logic w_unused_timeout_cfg;
   assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
   assign w_stall_to           = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      req_ready   = '0;
      w_accept    = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_pick_any) w_state_nxt = ST_LOCK;
         end
         ST_LOCK: begin
            // only the owner may see ready, and only while the UART is idle
            req_ready = r_grant & {NUM_REQ{tx_ready}};
            w_accept  = w_own_vld & tx_ready;
            if (w_accept) begin
               w_state_nxt = ST_ISSUE;
            end else if (w_stall_to) begin
               w_state_nxt = ST_IDLE;
               w_release   = 1'b1;
            end
         end
         ST_ISSUE: begin
            w_state_nxt = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (!tx_ready) w_state_nxt = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (tx_ready) begin
               if (r_last) begin
                  w_state_nxt = ST_IDLE;
                  w_release   = 1'b1;
               end else begin
                  w_state_nxt = ST_LOCK;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr     <= '0;
         r_owner   <= '0;
         r_grant   <= '0;
         r_tx_data <= '0;
         r_last    <= 1'b0;
      end else begin
         if ((r_state == ST_IDLE) && w_pick_any) begin
            r_grant <= w_pick_gnt;
            r_owner <= w_pick_idx;
         end
         if (w_accept) begin
            r_tx_data <= req_data[{r_owner, 3'b000} +: 8];
            r_last    <= req_last[r_owner];
         end
         // releasing moves priority just past the departing owner
         if (w_release) begin
            r_grant <= '0;
            r_ptr   <= w_ptr_after_owner;
            r_last  <= 1'b0;
         end
      end
   end

   assign grant    = r_grant;
   assign tx_data  = r_tx_data;
   assign tx_valid = (r_state == ST_ISSUE);
   assign busy     = (r_state != ST_IDLE);
   assign timeout  = w_stall_to;

endmodule
